// File: rtl/fpu_mac_sequencer.sv
// rtl/fpu_mac_sequencer.sv - K-step MAC job sequencer: fetches operand pairs, feeds the PE column, collects done pulses.
// Each step is FETCH -> LOAD -> WAIT; a per-step watchdog traps a silent PE into a sticky error state.
module fpu_mac_sequencer #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    k_len,
    input  logic          abort,
    output logic          rd_en,
    output logic [7:0]    rd_idx,
    input  logic [31:0]   rd_a,
    input  logic [31:0]   rd_b,
    output logic          pe_clr,
    output logic          pe_load,
    output logic [31:0]   pe_row,
    output logic [31:0]   pe_col,
    input  logic [N-1:0]  pe_done,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_FINISH,
        S_ERR
    } state_t;

    state_t          r_state;
    logic [7:0]      r_k;
    logic [7:0]      r_klen;
    logic [N-1:0]    r_cap;
    logic [WDW-1:0]  r_wd;
    logic            r_rd_en;
    logic [7:0]      r_rd_idx;
    logic            r_pe_clr;
    logic            r_pe_load;
    logic [31:0]     r_pe_row;
    logic [31:0]     r_pe_col;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic [N-1:0]    w_cap_next;
    logic            w_all_done;
    logic            w_last_step;

    // Done bits arriving this cycle count toward completion immediately.
    assign w_cap_next  = r_cap | pe_done;
    assign w_all_done  = &w_cap_next;
    assign w_last_step = (r_k == (r_klen - 8'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_klen    <= '0;
            r_cap     <= '0;
            r_wd      <= '0;
            r_rd_en   <= 1'b0;
            r_rd_idx  <= '0;
            r_pe_clr  <= 1'b0;
            r_pe_load <= 1'b0;
            r_pe_row  <= '0;
            r_pe_col  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_pe_clr  <= 1'b0;
            r_rd_en   <= 1'b0;
            r_pe_load <= 1'b0;
            r_done    <= 1'b0;

            // Abort outranks every other transition, including a same-cycle completion.
            if (abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            if (k_len == 8'd0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_klen   <= k_len;
                                r_k      <= '0;
                                r_busy   <= 1'b1;
                                r_pe_clr <= 1'b1;
                                r_state  <= S_CLR;
                            end
                        end
                    end
                    S_CLR: begin
                        r_rd_en  <= 1'b1;
                        r_rd_idx <= r_k;
                        r_state  <= S_FETCH;
                    end
                    S_FETCH: begin
                        r_state <= S_LOAD;
                    end
                    S_LOAD: begin
                        r_pe_row  <= rd_a;
                        r_pe_col  <= rd_b;
                        r_pe_load <= 1'b1;
                        r_cap     <= '0;
                        r_wd      <= '0;
                        r_state   <= S_WAIT;
                    end
                    S_WAIT: begin
                        r_cap <= w_cap_next;
                        if (w_all_done) begin
                            if (w_last_step) begin
                                r_done  <= 1'b1;
                                r_state <= S_FINISH;
                            end else begin
                                r_k      <= r_k + 8'd1;
                                r_rd_en  <= 1'b1;
                                r_rd_idx <= r_k + 8'd1;
                                r_state  <= S_FETCH;
                            end
                        end else if (r_wd == WD_LAST) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_ERR;
                        end else begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end
                    S_FINISH: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    S_ERR: begin
                        r_state <= S_ERR;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_en   = r_rd_en;
    assign rd_idx  = r_rd_idx;
    assign pe_clr  = r_pe_clr;
    assign pe_load = r_pe_load;
    assign pe_row  = r_pe_row;
    assign pe_col  = r_pe_col;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_fpu_mac_sequencer.sv
// tb/tb_fpu_mac_sequencer.sv - randomized job stimulus with a per-cycle expected-output timeline.
// Each job is expanded up front into cycle records (drive + expected outputs) and replayed in lockstep.
module tb_fpu_mac_sequencer;

    localparam int N  = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    k_len = '0;
    logic          abort = 1'b0;
    logic [31:0]   rd_a = '0;
    logic [31:0]   rd_b = '0;
    logic [N-1:0]  pe_done = '0;
    logic          rd_en;
    logic [7:0]    rd_idx;
    logic          pe_clr;
    logic          pe_load;
    logic [31:0]   pe_row;
    logic [31:0]   pe_col;
    logic          busy;
    logic          done;
    logic          err;

    fpu_mac_sequencer #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_a(rd_a), .rd_b(rd_b),
        .pe_clr(pe_clr), .pe_load(pe_load), .pe_row(pe_row), .pe_col(pe_col),
        .pe_done(pe_done), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         rst;
        logic         start;
        logic         abort;
        logic [7:0]   klen;
        logic [N-1:0] pdone;
        logic [31:0]  a;
        logic [31:0]  b;
        logic         e_clr;
        logic         e_rden;
        logic [7:0]   e_idx;
        logic         e_load;
        logic [31:0]  e_row;
        logic [31:0]  e_col;
        logic         e_busy;
        logic         e_done;
        logic         e_err;
        logic [3:0]   mark;
    } cyc_t;

    cyc_t job_q[$];
    cyc_t exp_q[$];
    logic m_err = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic cyc_t idle_rec();
        cyc_t r;
        r       = '0;
        r.klen  = 8'($urandom);
        r.a     = $urandom;
        r.b     = $urandom;
        r.pdone = N'($urandom);
        r.e_err = m_err;
        return r;
    endfunction

    function automatic cyc_t busy_rec(input bit bs);
        cyc_t r;
        r        = idle_rec();
        r.e_err  = 1'b0;
        r.e_busy = 1'b1;
        r.start  = bs && ($urandom_range(0, 2) == 0);
        return r;
    endfunction

    // mode 0 random delays (maybe a silent PE), 1 all at +2, 2 staggered with a repeat,
    // 3 bit 2 never arrives, 4 completion on the last watchdog cycle.
    task automatic add_job(input int klen, input int mode, input int cut_at,
                           input bit cut_rst, input bit bs, input logic [3:0] mk);
        cyc_t r;
        cyc_t act[$];
        int   d[N];
        int   m;
        bit   timed_out;
        logic [31:0] la, lb;
        r = idle_rec();
        r.start = 1'b1;
        r.klen  = 8'(klen);
        r.mark  = (mk != 0) ? 4'd1 : 4'd0;
        job_q.push_back(r);
        if (klen == 0) begin
            r = idle_rec();
            r.e_done = 1'b1;
            job_q.push_back(r);
        end else begin
            timed_out = 1'b0;
            r = busy_rec(bs);
            r.e_clr = 1'b1;
            act.push_back(r);
            for (int s = 0; s < klen && !timed_out; s++) begin
                r = busy_rec(bs);
                r.e_rden = 1'b1;
                r.e_idx  = 8'(s);
                act.push_back(r);
                r = busy_rec(bs);
                la = r.a;
                lb = r.b;
                act.push_back(r);
                for (int i = 0; i < N; i++) begin
                    case (mode)
                        1:       d[i] = 2;
                        2:       d[i] = i;
                        3:       d[i] = (i == 2) ? -1 : i;
                        4:       d[i] = (i == 1) ? TO - 1 : i;
                        default: d[i] = $urandom_range(0, TO - 1);
                    endcase
                end
                if (mode == 0 && $urandom_range(0, 9) == 0) d[$urandom_range(0, N - 1)] = -1;
                m = 0;
                for (int i = 0; i < N; i++) begin
                    if (d[i] < 0) timed_out = 1'b1;
                    else if (d[i] > m) m = d[i];
                end
                if (timed_out) m = TO - 1;
                for (int w = 0; w <= m; w++) begin
                    r = busy_rec(bs);
                    r.pdone = '0;
                    for (int i = 0; i < N; i++) begin
                        if (d[i] == w) r.pdone[i] = 1'b1;
                        else if (d[i] >= 0 && w > d[i] && $urandom_range(0, 3) == 0) r.pdone[i] = 1'b1;
                    end
                    if (mode == 2 && w == 2) r.pdone[1] = 1'b1;
                    if (bs && s == 1 && w == 0) r.start = 1'b1;
                    if (w == 0) begin
                        r.e_load = 1'b1;
                        r.e_row  = la;
                        r.e_col  = lb;
                    end
                    act.push_back(r);
                end
            end
            if (!timed_out) begin
                r = busy_rec(bs);
                r.e_done = 1'b1;
                act.push_back(r);
            end
            if (cut_at >= 0 && cut_at < act.size()) begin
                while (act.size() > cut_at + 1) void'(act.pop_back());
                if (cut_rst) begin
                    r = idle_rec();
                    r.rst = 1'b1;
                    act[cut_at] = r;
                end else begin
                    act[cut_at].abort = 1'b1;
                end
                timed_out = 1'b0;
            end
            foreach (act[i]) job_q.push_back(act[i]);
            if (timed_out) begin
                m_err = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    r = idle_rec();
                    r.start = (i == 1);
                    job_q.push_back(r);
                end
                r = idle_rec();
                r.abort = 1'b1;
                job_q.push_back(r);
                m_err = 1'b0;
            end
        end
        r = idle_rec();
        job_q.push_back(r);
        r = idle_rec();
        r.mark = mk;
        job_q.push_back(r);
    endtask

    task automatic play();
        cyc_t r;
        while (job_q.size() > 0) begin
            r = job_q.pop_front();
            @(posedge clk);
            #1;
            rst     = r.rst;
            start   = r.start;
            abort   = r.abort;
            k_len   = r.klen;
            pe_done = r.pdone;
            rd_a    = r.a;
            rd_b    = r.b;
            exp_q.push_back(r);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp_v);
        end
    endtask

    initial begin : compare
        cyc_t e;
        int c_clr, c_rden, c_load, c_done;
        c_clr = 0; c_rden = 0; c_load = 0; c_done = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.mark == 4'd1) begin
                    c_clr = 0; c_rden = 0; c_load = 0; c_done = 0;
                end
                c_clr  += int'(pe_clr);
                c_rden += int'(rd_en);
                c_load += int'(pe_load);
                c_done += int'(done);
                chk("pe_clr", 32'(pe_clr), 32'(e.e_clr));
                chk("rd_en", 32'(rd_en), 32'(e.e_rden));
                if (e.e_rden) chk("rd_idx", 32'(rd_idx), 32'(e.e_idx));
                chk("pe_load", 32'(pe_load), 32'(e.e_load));
                if (e.e_load) begin
                    chk("pe_row", pe_row, e.e_row);
                    chk("pe_col", pe_col, e.e_col);
                end
                chk("busy", 32'(busy), 32'(e.e_busy));
                chk("done", 32'(done), 32'(e.e_done));
                chk("err", 32'(err), 32'(e.e_err));
                case (e.mark)
                    4'd2: begin
                        chk("k3_clr_count", 32'(c_clr), 32'd1);
                        chk("k3_rden_count", 32'(c_rden), 32'd3);
                        chk("k3_load_count", 32'(c_load), 32'd3);
                        chk("k3_done_count", 32'(c_done), 32'd1);
                    end
                    4'd3: begin
                        chk("k4_load_count", 32'(c_load), 32'd4);
                        chk("k4_done_count", 32'(c_done), 32'd1);
                    end
                    4'd4: begin
                        chk("post_rst_load_count", 32'(c_load), 32'd1);
                        chk("post_rst_done_count", 32'(c_done), 32'd1);
                    end
                    4'd5: begin
                        chk("k0_rden_count", 32'(c_rden + c_load + c_clr), 32'd0);
                        chk("k0_done_count", 32'(c_done), 32'd1);
                    end
                    4'd6: begin
                        chk("stagger_load_count", 32'(c_load), 32'd2);
                        chk("stagger_done_count", 32'(c_done), 32'd1);
                    end
                    default: ;
                endcase
            end
        end
    end

    initial begin : stimulus
        cyc_t r;
        for (int i = 0; i < 3; i++) begin
            r = idle_rec();
            r.rst = 1'b1;
            job_q.push_back(r);
        end
        job_q.push_back(idle_rec());
        job_q.push_back(idle_rec());
        play();

        add_job(3, 1, -1, 1'b0, 1'b0, 4'd2);   play();
        add_job(0, 0, -1, 1'b0, 1'b0, 4'd5);   play();
        add_job(2, 2, -1, 1'b0, 1'b1, 4'd6);   play();
        add_job(2, 3, -1, 1'b0, 1'b0, 4'd0);   play();
        add_job(2, 4, -1, 1'b0, 1'b0, 4'd0);   play();
        add_job(4, 1, -1, 1'b0, 1'b1, 4'd3);   play();
        add_job(4, 1, 14, 1'b1, 1'b0, 4'd0);   play();
        add_job(1, 1, -1, 1'b0, 1'b0, 4'd4);   play();
        add_job(3, 0,  7, 1'b0, 1'b1, 4'd0);   play();
        add_job(255, 1, -1, 1'b0, 1'b1, 4'd0); play();

        for (int j = 0; j < 80; j++) begin
            add_job($urandom_range(0, 7), 0,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 24) : -1,
                    1'(($urandom_range(0, 1))), 1'b1, 4'd0);
            play();
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_mac_sequencer.md
FPU_MAC_SEQUENCER -- requirements
Module: fpu_mac_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: number of PE done lines monitored (one PE column).
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for all PE done pulses per step.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to run a K-step multiply-accumulate job.
REQ-006 SHALL have port k_len  input  8  number of accumulate steps, sampled when start is accepted.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current job.
REQ-008 SHALL have port rd_en  output  1  operand fetch strobe.
REQ-009 SHALL have port rd_idx  output  8  step index k of the operand pair being fetched.
REQ-010 SHALL have port rd_a  input  32  IEEE-754 single row operand, valid the cycle after rd_en.
REQ-011 SHALL have port rd_b  input  32  IEEE-754 single column operand, valid the cycle after rd_en.
REQ-012 SHALL have port pe_clr  output  1  one-cycle accumulator clear pulse to the PEs.
REQ-013 SHALL have port pe_load  output  1  load_in pulse to the PE chain.
REQ-014 SHALL have port pe_row  output  32  registered row operand to the PE chain.
REQ-015 SHALL have port pe_col  output  32  registered column operand to the PE chain.
REQ-016 SHALL have port pe_done  input  N  done_pe pulses from the N PEs.
REQ-017 SHALL have port busy  output  1  high from start acceptance until return to IDLE/ERR.
REQ-018 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-019 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-020 SHALL implement states IDLE, CLR, FETCH, LOAD, WAIT, FINISH, ERR.
REQ-021 IDLE: start with k_len!=0 SHALL latch k_len, set k=0, busy=1, go to CLR.
REQ-022 IDLE: start with k_len==0 SHALL pulse done the next cycle, issue no pe_clr/rd_en/pe_load, stay IDLE.
REQ-023 CLR SHALL assert pe_clr for exactly one cycle, then go to FETCH.
REQ-024 FETCH SHALL assert rd_en for one cycle with rd_idx=k, then go to LOAD.
REQ-025 LOAD SHALL register pe_row<=rd_a, pe_col<=rd_b, pulse pe_load one cycle, clear done-capture vector and watchdog, go to WAIT.
REQ-026 WAIT SHALL OR each pe_done bit into a sticky N-bit capture vector; a bit pulsing more than once SHALL count once.
REQ-027 WAIT: when capture vector becomes all-ones (including bits arriving that cycle) and k<k_len-1, SHALL increment k and go to FETCH.
REQ-028 WAIT: when capture vector becomes all-ones and k==k_len-1, SHALL go to FINISH.
REQ-029 WAIT watchdog SHALL count cycles; on reaching TIMEOUT without completion SHALL go to ERR; completion in the same cycle wins.
REQ-030 FINISH SHALL pulse done one cycle, deassert busy, return to IDLE.
REQ-031 ERR SHALL hold err=1, busy=0; only abort or rst SHALL leave ERR (to IDLE, err cleared).
REQ-032 pe_done bits outside WAIT SHALL be ignored.
REQ-033 start while busy SHALL be ignored; k_len changes while busy SHALL have no effect.
REQ-034 abort in any non-IDLE state SHALL return to IDLE next cycle, busy=0, no done pulse; abort has priority over start and completion.
REQ-035 Minimum step latency SHALL be 3 cycles (FETCH, LOAD, WAIT with done in first WAIT cycle).

Reset
REQ-036 rst SHALL force IDLE, k=0, capture vector=0, watchdog=0, and rd_en, rd_idx, pe_clr, pe_load, pe_row, pe_col, busy, done, err all 0.
REQ-037 rst mid-job SHALL discard the job with no done pulse; the next start SHALL run normally.

Verification
REQ-038 k_len=3, N=4, all pe_done pulse 2 cycles after pe_load -> one pe_clr, rd_idx 0,1,2, three pe_load, one done, pe_row/pe_col equal rd_a/rd_b of each step.
REQ-039 k_len=0 start -> done pulse next cycle, busy stays 0, no rd_en/pe_load.
REQ-040 pe_done bits 0..3 staggered over 4 cycles, bit 1 pulsed twice -> step advances only after bit 3, exactly once.
REQ-041 TIMEOUT=8, pe_done[2] never pulses -> err=1 at 8 WAIT cycles, busy=0; abort -> err=0, IDLE.
REQ-042 start during WAIT of step 1 of k_len=4 job -> ignored, job completes with 4 loads, single done.
REQ-043 rst asserted in WAIT of step 2 -> all outputs 0 immediately; new start with k_len=1 -> one load, one done.
